// File: rtl/fano_sim_pkg.sv
// Shared definitions for the Fano decoder simulation environment:
// default field widths, sweep-sequencer state codes and a saturating subtract.
package fano_sim_pkg;

    localparam int W_RATE_DEF = 12;
    localparam int W_CNT_DEF  = 16;
    localparam int W_STEP_DEF = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ARM    = 3'd1;
    localparam logic [2:0] ST_RUN    = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_REPORT = 3'd4;
    localparam logic [2:0] ST_NEXT   = 3'd5;
    localparam logic [2:0] ST_FIN    = 3'd6;

    // Borrow out of the extra top bit means b > a; clamp to the floor instead of wrapping.
    function automatic logic [31:0] sat_sub(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] floor_val);
        logic [32:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        if (diff[32] || (diff[31:0] < floor_val))
            sat_sub = floor_val;
        else
            sat_sub = diff[31:0];
    endfunction

endpackage

// File: rtl/err_sweep_ctrl_sat_acc.sv
// Saturating accumulator: synchronous clear, conditional add, sticks at all-ones.
module sat_acc #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] add,
    output logic [W-1:0] q
);

    logic [W-1:0] acc_q;
    logic [W-1:0] acc_d;
    logic [W:0]   sum;

    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, add};
        acc_d = acc_q;
        if (clr)
            acc_d = '0;
        else if (en)
            acc_d = sum[W] ? '1 : sum[W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end

    assign q = acc_q;

endmodule

// File: rtl/err_sweep_ctrl.sv
// Bit-error-rate sweep sequencer: programs the error injector per step, gates the
// word source, counts decoder words/bit errors and walks the error period down.
module err_sweep_ctrl
    import fano_sim_pkg::*;
#(
    parameter int W_RATE        = W_RATE_DEF,
    parameter int W_CNT         = W_CNT_DEF,
    parameter int W_STEP        = W_STEP_DEF,
    parameter int ARM_CYCLES    = 2,
    parameter int DRAIN_TIMEOUT = 1024,
    parameter int MIN_RATE      = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [W_STEP-1:0] i_num_steps,
    input  logic [W_CNT-1:0]  i_words_per_step,
    input  logic [W_RATE-1:0] i_first_err,
    input  logic [W_RATE-1:0] i_rate_init,
    input  logic [W_RATE-1:0] i_rate_dec,
    input  logic              i_src_vld,
    input  logic              i_dec_vld,
    input  logic [W_CNT-1:0]  i_dec_err,
    output logic [W_RATE-1:0] o_first_err,
    output logic [W_RATE-1:0] o_err_rate,
    output logic              o_inj_reset_n,
    output logic              o_src_en,
    output logic              o_busy,
    output logic              o_step_vld,
    output logic [W_STEP-1:0] o_step_idx,
    output logic [W_RATE-1:0] o_step_rate,
    output logic [W_CNT-1:0]  o_step_errs,
    output logic [W_CNT-1:0]  o_step_words,
    output logic              o_step_timeout,
    output logic              o_done
);

    localparam int AW = $clog2(ARM_CYCLES + 1);
    localparam int TW = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [W_CNT:0] ONE_EXT = 1;

    logic [2:0]        state_q, state_d;
    logic [W_STEP-1:0] num_steps_q, num_steps_d;
    logic [W_STEP-1:0] step_idx_q, step_idx_d;
    logic [W_CNT-1:0]  words_q, words_d;
    logic [W_RATE-1:0] rate_dec_q, rate_dec_d;
    logic [W_RATE-1:0] first_err_q, first_err_d;
    logic [W_RATE-1:0] err_rate_q, err_rate_d;
    logic [AW-1:0]     arm_cnt_q, arm_cnt_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              timeout_q, timeout_d;
    logic [W_STEP-1:0] res_idx_q, res_idx_d;
    logic [W_RATE-1:0] res_rate_q, res_rate_d;
    logic [W_CNT-1:0]  res_errs_q, res_errs_d;
    logic [W_CNT-1:0]  res_words_q, res_words_d;
    logic              res_timeout_q, res_timeout_d;
    logic              step_vld_q, step_vld_d;
    logic              done_q, done_d;

    logic              cnt_clr;
    logic              src_inc;
    logic              dec_inc;
    logic              src_last;
    logic [W_CNT-1:0]  src_cnt;
    logic [W_CNT-1:0]  dec_cnt;
    logic [W_CNT-1:0]  err_acc;

    sat_acc #(.W(W_CNT)) u_src_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .en      (src_inc),
        .add     (W_CNT'(1)),
        .q       (src_cnt)
    );

    sat_acc #(.W(W_CNT)) u_dec_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .en      (dec_inc),
        .add     (W_CNT'(1)),
        .q       (dec_cnt)
    );

    sat_acc #(.W(W_CNT)) u_err_acc (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .en      (dec_inc),
        .add     (i_dec_err),
        .q       (err_acc)
    );

    always_comb begin
        state_d       = state_q;
        num_steps_d   = num_steps_q;
        step_idx_d    = step_idx_q;
        words_d       = words_q;
        rate_dec_d    = rate_dec_q;
        first_err_d   = first_err_q;
        err_rate_d    = err_rate_q;
        arm_cnt_d     = arm_cnt_q;
        timer_d       = timer_q;
        timeout_d     = timeout_q;
        res_idx_d     = res_idx_q;
        res_rate_d    = res_rate_q;
        res_errs_d    = res_errs_q;
        res_words_d   = res_words_q;
        res_timeout_d = res_timeout_q;
        step_vld_d    = 1'b0;
        done_d        = 1'b0;

        cnt_clr  = (state_q == ST_ARM);
        src_inc  = (state_q == ST_RUN) && i_src_vld;
        dec_inc  = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && i_dec_vld;
        src_last = src_inc && (({1'b0, src_cnt} + ONE_EXT) >= {1'b0, words_q});

        // Abort leaves every result and injector register untouched; only the FSM returns home.
        if (i_abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        num_steps_d = i_num_steps;
                        words_d     = (i_words_per_step == '0) ? W_CNT'(1) : i_words_per_step;
                        rate_dec_d  = i_rate_dec;
                        step_idx_d  = '0;
                        if (i_num_steps == '0) begin
                            state_d = ST_FIN;
                        end else begin
                            state_d     = ST_ARM;
                            arm_cnt_d   = '0;
                            first_err_d = i_first_err;
                            err_rate_d  = i_rate_init;
                        end
                    end
                end
                ST_ARM: begin
                    if (arm_cnt_q == AW'(ARM_CYCLES - 1))
                        state_d = ST_RUN;
                    else
                        arm_cnt_d = arm_cnt_q + AW'(1);
                end
                ST_RUN: begin
                    if (src_last) begin
                        state_d = ST_DRAIN;
                        timer_d = '0;
                    end
                end
                ST_DRAIN: begin
                    if (dec_cnt == words_q) begin
                        state_d   = ST_REPORT;
                        timeout_d = 1'b0;
                    end else if (timer_q == TW'(DRAIN_TIMEOUT - 1)) begin
                        state_d   = ST_REPORT;
                        timeout_d = 1'b1;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                ST_REPORT: begin
                    res_idx_d     = step_idx_q;
                    res_rate_d    = err_rate_q;
                    res_errs_d    = err_acc;
                    res_words_d   = dec_cnt;
                    res_timeout_d = timeout_q;
                    step_vld_d    = 1'b1;
                    state_d       = ST_NEXT;
                end
                ST_NEXT: begin
                    if (({1'b0, step_idx_q} + 1'b1) == {1'b0, num_steps_q}) begin
                        state_d = ST_FIN;
                    end else begin
                        step_idx_d = step_idx_q + W_STEP'(1);
                        err_rate_d = W_RATE'(sat_sub(32'(err_rate_q), 32'(rate_dec_q), 32'(MIN_RATE)));
                        arm_cnt_d  = '0;
                        state_d    = ST_ARM;
                    end
                end
                ST_FIN: begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            num_steps_q   <= '0;
            step_idx_q    <= '0;
            words_q       <= '0;
            rate_dec_q    <= '0;
            first_err_q   <= '0;
            err_rate_q    <= '0;
            arm_cnt_q     <= '0;
            timer_q       <= '0;
            timeout_q     <= 1'b0;
            res_idx_q     <= '0;
            res_rate_q    <= '0;
            res_errs_q    <= '0;
            res_words_q   <= '0;
            res_timeout_q <= 1'b0;
            step_vld_q    <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            num_steps_q   <= num_steps_d;
            step_idx_q    <= step_idx_d;
            words_q       <= words_d;
            rate_dec_q    <= rate_dec_d;
            first_err_q   <= first_err_d;
            err_rate_q    <= err_rate_d;
            arm_cnt_q     <= arm_cnt_d;
            timer_q       <= timer_d;
            timeout_q     <= timeout_d;
            res_idx_q     <= res_idx_d;
            res_rate_q    <= res_rate_d;
            res_errs_q    <= res_errs_d;
            res_words_q   <= res_words_d;
            res_timeout_q <= res_timeout_d;
            step_vld_q    <= step_vld_d;
            done_q        <= done_d;
        end
    end

    // Injector runs only while a step is live; it is held in reset in IDLE, ARM and FIN.
    assign o_inj_reset_n  = (state_q == ST_RUN) || (state_q == ST_DRAIN) ||
                            (state_q == ST_REPORT) || (state_q == ST_NEXT);
    assign o_src_en       = (state_q == ST_RUN);
    assign o_busy         = (state_q != ST_IDLE);
    assign o_first_err    = first_err_q;
    assign o_err_rate     = err_rate_q;
    assign o_step_vld     = step_vld_q;
    assign o_step_idx     = res_idx_q;
    assign o_step_rate    = res_rate_q;
    assign o_step_errs    = res_errs_q;
    assign o_step_words   = res_words_q;
    assign o_step_timeout = res_timeout_q;
    assign o_done         = done_q;

endmodule

// File: tb/tb_err_sweep_ctrl.sv
// Randomised bench for err_sweep_ctrl: emulates word source and decoder and compares
// each step report against sweep results derived from the generated traffic.
module tb_err_sweep_ctrl;

    localparam int ARM_CYCLES    = 2;
    localparam int DRAIN_TIMEOUT = 1024;
    localparam int CYCLE_BUDGET  = 20000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_start;
    logic        i_abort;
    logic [7:0]  i_num_steps;
    logic [15:0] i_words_per_step;
    logic [11:0] i_first_err;
    logic [11:0] i_rate_init;
    logic [11:0] i_rate_dec;
    logic        i_src_vld;
    logic        i_dec_vld;
    logic [15:0] i_dec_err;
    logic [11:0] o_first_err;
    logic [11:0] o_err_rate;
    logic        o_inj_reset_n;
    logic        o_src_en;
    logic        o_busy;
    logic        o_step_vld;
    logic [7:0]  o_step_idx;
    logic [11:0] o_step_rate;
    logic [15:0] o_step_errs;
    logic [15:0] o_step_words;
    logic        o_step_timeout;
    logic        o_done;

    err_sweep_ctrl #(
        .W_RATE        (12),
        .W_CNT         (16),
        .W_STEP        (8),
        .ARM_CYCLES    (ARM_CYCLES),
        .DRAIN_TIMEOUT (DRAIN_TIMEOUT),
        .MIN_RATE      (1)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_start          (i_start),
        .i_abort          (i_abort),
        .i_num_steps      (i_num_steps),
        .i_words_per_step (i_words_per_step),
        .i_first_err      (i_first_err),
        .i_rate_init      (i_rate_init),
        .i_rate_dec       (i_rate_dec),
        .i_src_vld        (i_src_vld),
        .i_dec_vld        (i_dec_vld),
        .i_dec_err        (i_dec_err),
        .o_first_err      (o_first_err),
        .o_err_rate       (o_err_rate),
        .o_inj_reset_n    (o_inj_reset_n),
        .o_src_en         (o_src_en),
        .o_busy           (o_busy),
        .o_step_vld       (o_step_vld),
        .o_step_idx       (o_step_idx),
        .o_step_rate      (o_step_rate),
        .o_step_errs      (o_step_errs),
        .o_step_words     (o_step_words),
        .o_step_timeout   (o_step_timeout),
        .o_done           (o_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [15:0] err;
    } dec_item_t;

    dec_item_t decQ[$];
    int compared   = 0;
    int mismatched = 0;
    int lastErrs   = 0;
    int lastWords  = 0;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // One sweep; stopAt >= 0 cuts it short by abort (or reset) after that many source words.
    task automatic applyStimulus(input int numSteps, input int words, input int firstErr,
                                 input int rInit, input int rDec, input int dropN,
                                 input int errMode, input int stopAt, input bit stopByReset);
        int rates[$];
        int wordsEff, cyc, stepSeen, accThis, accTotal, errSum, expErrs;
        int lowRun, srcLowAt, r;
        bit prevSrcEn, firstSrcSeen, stopIssued, finished;
        logic [15:0] errVal;

        wordsEff = (words == 0) ? 1 : words;
        for (int k = 0; k < numSteps; k++) begin
            if (k == 0) r = rInit;
            else begin
                r = rates[k-1] - rDec;
                if (r < 1) r = 1;
            end
            rates.push_back(r);
        end
        decQ.delete();
        stepSeen = 0; accThis = 0; accTotal = 0; errSum = 0;
        lowRun = 0; srcLowAt = 0; prevSrcEn = 0; firstSrcSeen = 0;
        stopIssued = 0; finished = 0;

        @(negedge clk);
        i_num_steps      = 8'(numSteps);
        i_words_per_step = 16'(words);
        i_first_err      = 12'(firstErr);
        i_rate_init      = 12'(rInit);
        i_rate_dec       = 12'(rDec);
        i_start          = 1'b1;
        cyc = 0;

        while (!finished) begin
            @(negedge clk);
            cyc++;
            i_start   = 1'b0;
            i_abort   = 1'b0;
            i_src_vld = 1'b0;
            i_dec_vld = 1'b0;
            i_dec_err = 16'($urandom);

            if (stopIssued) begin
                checkOutput("stop_src_en", int'(o_src_en), 0);
                checkOutput("stop_busy", int'(o_busy), 0);
                checkOutput("stop_inj_reset_n", int'(o_inj_reset_n), 0);
                checkOutput("stop_step_vld", int'(o_step_vld), 0);
                checkOutput("stop_done", int'(o_done), 0);
                if (stopByReset) begin
                    checkOutput("reset_step_errs", int'(o_step_errs), 0);
                    checkOutput("reset_step_words", int'(o_step_words), 0);
                    checkOutput("reset_err_rate", int'(o_err_rate), 0);
                    lastErrs  = 0;
                    lastWords = 0;
                end else begin
                    checkOutput("abort_keeps_errs", int'(o_step_errs), lastErrs);
                    checkOutput("abort_keeps_words", int'(o_step_words), lastWords);
                end
                reset_n = 1'b1;
                decQ.delete();
                finished = 1;
            end else begin
                if (o_busy && o_inj_reset_n && stepSeen < numSteps) begin
                    checkOutput("err_rate_stable", int'(o_err_rate), rates[stepSeen]);
                    checkOutput("first_err", int'(o_first_err), firstErr);
                end
                if (o_step_vld) begin
                    if (stepSeen < numSteps) begin
                        expErrs = (errSum > 65535) ? 65535 : errSum;
                        checkOutput("step_idx", int'(o_step_idx), stepSeen);
                        checkOutput("step_rate", int'(o_step_rate), rates[stepSeen]);
                        checkOutput("step_errs", int'(o_step_errs), expErrs);
                        checkOutput("step_words", int'(o_step_words), wordsEff - dropN);
                        checkOutput("step_timeout", int'(o_step_timeout), (dropN > 0) ? 1 : 0);
                        checkOutput("src_words", accThis, wordsEff);
                        if (dropN > 0)
                            checkOutput("drain_length", int'((cyc - srcLowAt) >= DRAIN_TIMEOUT &&
                                                             (cyc - srcLowAt) <= DRAIN_TIMEOUT + 2), 1);
                        lastErrs  = expErrs;
                        lastWords = wordsEff - dropN;
                    end else begin
                        checkOutput("extra_step_vld", stepSeen, numSteps - 1);
                    end
                    stepSeen++;
                    accThis = 0;
                    errSum  = 0;
                end
                if (o_done) begin
                    checkOutput("steps_at_done", stepSeen, numSteps);
                    if (numSteps == 0) checkOutput("done_latency", cyc, 2);
                    finished = 1;
                end
                if (o_src_en && !firstSrcSeen) begin
                    firstSrcSeen = 1;
                    checkOutput("src_en_latency", cyc, 1 + ARM_CYCLES);
                end
                if (prevSrcEn && !o_src_en) srcLowAt = cyc;
                prevSrcEn = o_src_en;
                if (!o_busy) lowRun = 0;
                else if (!o_inj_reset_n) lowRun++;
                else if (lowRun > 0) begin
                    checkOutput("inj_reset_len", lowRun, ARM_CYCLES);
                    lowRun = 0;
                end

                if (stopAt >= 0 && accTotal >= stopAt && o_src_en) begin
                    if (stopByReset) reset_n = 1'b0;
                    else i_abort = 1'b1;
                    stopIssued = 1;
                end else if (o_src_en) begin
                    if ($urandom_range(0, 3) != 0) begin
                        i_src_vld = 1'b1;
                        case (errMode)
                            0:       errVal = 16'd1;
                            2:       errVal = 16'hFFFF;
                            default: errVal = 16'($urandom_range(0, 7));
                        endcase
                        if (accThis < wordsEff - dropN) begin
                            decQ.push_back('{cyc + $urandom_range(1, 4), errVal});
                            errSum += int'(errVal);
                        end
                        accThis++;
                        accTotal++;
                    end
                end else begin
                    i_src_vld = ($urandom_range(0, 7) == 0);
                end
                if (decQ.size() > 0 && decQ[0].due <= cyc) begin
                    i_dec_vld = 1'b1;
                    i_dec_err = decQ[0].err;
                    void'(decQ.pop_front());
                end
            end

            if (!finished && cyc > CYCLE_BUDGET) begin
                checkOutput("cycle_budget", cyc, CYCLE_BUDGET);
                finished = 1;
            end
        end
    endtask

    initial begin
        reset_n          = 1'b0;
        i_start          = 1'b0;
        i_abort          = 1'b0;
        i_num_steps      = '0;
        i_words_per_step = '0;
        i_first_err      = '0;
        i_rate_init      = '0;
        i_rate_dec       = '0;
        i_src_vld        = 1'b0;
        i_dec_vld        = 1'b0;
        i_dec_err        = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_inj_reset_n", int'(o_inj_reset_n), 0);
        checkOutput("rst_src_en", int'(o_src_en), 0);
        checkOutput("rst_busy", int'(o_busy), 0);
        checkOutput("rst_step_vld", int'(o_step_vld), 0);
        checkOutput("rst_done", int'(o_done), 0);
        checkOutput("rst_err_rate", int'(o_err_rate), 0);
        checkOutput("rst_step_errs", int'(o_step_errs), 0);
        reset_n = 1'b1;

        applyStimulus(3, 8, 5, 10, 3, 0, 0, -1, 1'b0);
        applyStimulus(3, 8, 7, 5, 4, 0, 1, -1, 1'b0);
        applyStimulus(2, 8, 3, 20, 5, 2, 1, -1, 1'b0);
        applyStimulus(3, 8, 1, 30, 2, 0, 1, 5, 1'b0);
        applyStimulus(2, 8, 1, 9, 1, 0, 1, -1, 1'b0);
        applyStimulus(0, 8, 4, 12, 1, 0, 1, -1, 1'b0);
        applyStimulus(3, 0, 2, 7, 2, 0, 1, -1, 1'b0);
        applyStimulus(1, 8, 6, 40, 1, 0, 2, -1, 1'b0);
        for (int t = 0; t < 4; t++)
            applyStimulus($urandom_range(1, 4), $urandom_range(0, 12), $urandom_range(0, 4095),
                          $urandom_range(1, 4095), $urandom_range(0, 1500), 0, 1, -1, 1'b0);
        applyStimulus(2, 8, 3, 100, 10, 0, 1, 3, 1'b1);
        applyStimulus(2, 4, 3, 50, 60, 0, 1, -1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
